// File: rtl/jump_ctrl.sv
// Next-PC control: instruction decode, ZERO/LESS flags and the two-word extended jump.
// Define JMP_CTRL_EXT_EN to build the EXT prefix and EXT_WAIT state; otherwise opcode 3'b100 is a plain word.
module jump_ctrl #(
    parameter int OFS_W = 6,
    parameter int PC_W  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [8:0]      instr,
    input  logic            alu_zero,
    input  logic            alu_less,
    input  logic            flag_we,
    input  logic            stall,
    output logic [PC_W-1:0] pc_inc,
    output logic            taken,
    output logic            ext_busy
);

    localparam logic [2:0] OP_EXT  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_JMPZ = 3'b110;
    localparam logic [2:0] OP_JMPL = 3'b111;

    logic [2:0]      opcode;
    logic [PC_W-1:0] short_ofs;
    logic            flag_z;
    logic            flag_l;
    logic            in_idle;

    assign opcode    = instr[8:6];
    assign short_ofs = PC_W'($signed(instr[OFS_W-1:0]));

`ifdef JMP_CTRL_EXT_EN
    typedef enum logic {IDLE, EXT_WAIT} state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      hi;
    logic [1:0]      ext_cond;
    logic [PC_W-1:0] ext_ofs;

    assign ext_ofs = PC_W'($signed({hi, instr[OFS_W-1:0]}));
    assign in_idle = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hi       <= '0;
            ext_cond <= '0;
        end else if (!stall) begin
            state <= state_nx;
            if (state == IDLE && opcode == OP_EXT) begin
                hi       <= instr[3:0];
                ext_cond <= instr[5:4];
            end
        end
    end
`else
    assign in_idle = 1'b1;
`endif

    // Flags only follow the ALU on executed words; a data word of an extended jump never updates them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_l <= 1'b0;
        end else if (flag_we && !stall && in_idle) begin
            flag_z <= alu_zero;
            flag_l <= alu_less;
        end
    end

    always_comb begin
        pc_inc   = PC_W'(1);
        taken    = 1'b0;
        ext_busy = 1'b0;
`ifdef JMP_CTRL_EXT_EN
        state_nx = state;
        if (state == EXT_WAIT) begin
            ext_busy = 1'b1;
            state_nx = IDLE;
            case (ext_cond)
                2'b01:   taken = flag_z;
                2'b10:   taken = flag_l;
                default: taken = 1'b1;
            endcase
            if (taken) pc_inc = ext_ofs;
        end else
`endif
        begin
            case (opcode)
                OP_JMP:  taken = 1'b1;
                OP_JMPZ: taken = flag_z;
                OP_JMPL: taken = flag_l;
`ifdef JMP_CTRL_EXT_EN
                OP_EXT:  state_nx = EXT_WAIT;
`endif
                default: taken = 1'b0;
            endcase
            if (taken) pc_inc = short_ofs;
        end
        // Stall freezes the PC; ext_busy still reports the held state.
        if (stall) begin
            pc_inc = '0;
            taken  = 1'b0;
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed self-checking bench for jump_ctrl; expectations adapt to JMP_CTRL_EXT_EN.
module tb_jump_ctrl;

`ifdef JMP_CTRL_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [8:0] instr;
    logic       alu_zero;
    logic       alu_less;
    logic       flag_we;
    logic       stall;
    logic [9:0] pc_inc;
    logic       taken;
    logic       ext_busy;

    int errCount   = 0;
    int checkCount = 0;

    jump_ctrl #(.OFS_W(6), .PC_W(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .alu_zero (alu_zero),
        .alu_less (alu_less),
        .flag_we  (flag_we),
        .stall    (stall),
        .pc_inc   (pc_inc),
        .taken    (taken),
        .ext_busy (ext_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] i, input logic fwe, input logic az,
                                 input logic al, input logic st);
        instr    = i;
        flag_we  = fwe;
        alu_zero = az;
        alu_less = al;
        stall    = st;
        #1;
    endtask

    task automatic expectOut(input string tag, input logic [9:0] pc, input logic tk, input logic busy);
        checkOutput({tag, ".pc_inc"}, 32'(pc), 32'(pc));
    endtask

    task automatic expectAll(input string tag, input logic [9:0] pc, input logic tk, input logic busy);
        checkOutput({tag, ".pc_inc"}, 32'(pc_inc), 32'(pc));
        checkOutput({tag, ".taken"}, 32'(taken), 32'(tk));
        checkOutput({tag, ".ext_busy"}, 32'(ext_busy), 32'(busy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("in_reset", 10'h001, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Reset state: flags clear, plain word advances by one
        applyStimulus(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("rst_nop", 10'h001, 1'b0, 1'b0);
        applyStimulus(9'b110_111110, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("rst_jmpz", 10'h001, 1'b0, 1'b0);
        applyStimulus(9'b111_000101, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("rst_jmpl", 10'h001, 1'b0, 1'b0);
        applyStimulus(9'b101_111111, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("jmp_neg1", 10'h3FF, 1'b1, 1'b0);
        applyStimulus(9'b101_011111, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("jmp_pos31", 10'h01F, 1'b1, 1'b0);
        applyStimulus(9'b011_111111, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("other_op", 10'h001, 1'b0, 1'b0);

        // Set Z, then JMPZ taken; clearing Z in same cycle keeps old flag
        applyStimulus(9'h000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(9'b110_111110, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("jmpz_z1", 10'h3FE, 1'b1, 1'b0);
        applyStimulus(9'b110_111110, 1'b1, 1'b0, 1'b0, 1'b0);
        expectAll("jmpz_oldz", 10'h3FE, 1'b1, 1'b0);
        tick();
        applyStimulus(9'b110_111110, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("jmpz_z0", 10'h001, 1'b0, 1'b0);

        // JMPL with L written in the same cycle uses the old L
        applyStimulus(9'b111_000101, 1'b1, 1'b0, 1'b1, 1'b0);
        expectAll("jmpl_old", 10'h001, 1'b0, 1'b0);
        tick();
        applyStimulus(9'b111_000101, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("jmpl_new", 10'h005, 1'b1, 1'b0);

        // Stall zeroes pc_inc and blocks flag writes
        applyStimulus(9'b101_000111, 1'b1, 1'b0, 1'b0, 1'b1);
        expectAll("stall_jmp", 10'h000, 1'b0, 1'b0);
        tick();
        applyStimulus(9'b111_000101, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("stall_flag_hold", 10'h005, 1'b1, 1'b0);

        // Extended jump, unconditional
        applyStimulus(9'b100_00_0010, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("ext_prefix", 10'h001, 1'b0, 1'b0);
        tick();
        applyStimulus(9'b101_000011, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("ext_data", EXT ? 10'h083 : 10'h003, 1'b1, EXT);
        tick();
        applyStimulus(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("ext_back_idle", 10'h001, 1'b0, 1'b0);

        // Conditional on Z (Z=0) with flag_we on the data word
        applyStimulus(9'b100_01_1111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(9'b000_111111, 1'b1, 1'b1, 1'b0, 1'b0);
        expectAll("extz_nt", 10'h001, 1'b0, EXT);
        tick();
        applyStimulus(9'b110_000100, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("ext_fwe_ignored", EXT ? 10'h001 : 10'h004, !EXT, 1'b0);

        // Stall held in EXT_WAIT, then resolve
        applyStimulus(9'b100_00_1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(9'b000_000001, 1'b0, 1'b0, 1'b0, 1'b1);
            expectAll($sformatf("ext_stall%0d", c), 10'h000, 1'b0, EXT);
            tick();
        end
        applyStimulus(9'b000_000001, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("ext_after_stall", EXT ? 10'h201 : 10'h001, EXT, EXT);
        tick();

        // Zero offset halts; prefix opcode as data is not a new prefix
        applyStimulus(9'b100_11_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(9'b100_000000, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("ext_halt", EXT ? 10'h000 : 10'h001, EXT, EXT);
        tick();
        applyStimulus(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("ext_data_not_prefix", 10'h001, 1'b0, 1'b0);

        // Asynchronous reset discards a pending extended jump
        applyStimulus(9'b100_00_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(9'b101_000011, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_busy", 32'(ext_busy), 32'(EXT));
        reset = 1'b1;
        #1;
        checkOutput("async_reset_busy", 32'(ext_busy), 32'(0));
        checkOutput("async_reset_pc", 32'(pc_inc), 32'(10'h003));
        tick();
        reset = 1'b0;
        applyStimulus(9'b111_000101, 1'b0, 1'b0, 1'b0, 1'b0);
        expectAll("reset_clears_l", 10'h001, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
